// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver that feeds the DAC register:
//   - baud selection codes, which are the same 3-bit codes the transmitter uses
//   - the oversample divisor function div_of()
//   - the receiver FSM state type
//   - the oversampling ratio and the sample-index constants
//   - maj3(), the three-sample majority vote
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    localparam int DIV_W = 16;
    localparam int OVS   = 16;

    // Sample-counter values inside one bit period: vote samples, then end of bit.
    localparam logic [3:0] SMP_A    = 4'd6;
    localparam logic [3:0] SMP_B    = 4'd7;
    localparam logic [3:0] SMP_C    = 4'd8;
    localparam logic [3:0] SMP_LAST = 4'd15;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    // Clocks per oversample tick, truncated. Codes 5-7 fall back to 9600 baud.
    function automatic logic [DIV_W-1:0] div_of(input int clk_freq, input logic [2:0] code);
        int baud;
        case (code)
            BAUD_19200:  baud = 19200;
            BAUD_38400:  baud = 38400;
            BAUD_57600:  baud = 57600;
            BAUD_115200: baud = 115200;
            default:     baud = 9600;
        endcase
        return DIV_W'(clk_freq / (baud * OVS));
    endfunction

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_rx_baud_tick
// Generates the 16x oversample tick for the receiver. The divisor is latched
// from baud_set on the load pulse, so a baud change never affects a frame
// that is already in flight.
// Ports:
//   clk, rst_n  system clock, synchronous active-low reset
//   en          counter runs while high; it is held at 0 while low
//   load        latch the divisor for baud_set (on the IDLE->START transition)
//   baud_set    3-bit baud code
//   tick        one-cycle pulse when the counter reaches DIV-1
// ---------------------------------------------------------------------------
module uart_rx_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       load,
    input  logic [2:0] baud_set,
    output logic       tick
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;
    logic             at_end;

    assign at_end = (cnt == div_q - ONE);
    assign tick   = en && at_end;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, whatever order the statements appear in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= div_of(CLK_FREQ, BAUD_9600);
            cnt   <= '0;
        end else begin
            if (load) begin
                div_q <= div_of(CLK_FREQ, baud_set);
            end
            if (!en || at_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/da_uart_rx.sv
// ---------------------------------------------------------------------------
// da_uart_rx
// 8N1 UART receiver that uses 16x oversampling and a 3-sample majority vote.
// Each valid byte is strobed on rx_done and latched into the DAC holding
// register.
// Ports:
//   clk, rst_n  system clock, synchronous active-low reset
//   baud_set    baud code (0..4 = 9600..115200; codes 5-7 select 9600)
//   rs232_rx    asynchronous serial line, idle high
//   data_byte   last valid received byte
//   rx_done     one-cycle pulse for a valid frame
//   frame_err   one-cycle pulse when the stop bit is sampled low
//   rx_busy     high while the FSM is not in IDLE
//   dac_data    DAC data bus; it changes only on valid frames
//   clk_da      DAC clock, a pass-through of clk
// ---------------------------------------------------------------------------
module da_uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] baud_set,
    input  logic       rs232_rx,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy,
    output logic [7:0] dac_data,
    output logic       clk_da
);

    rx_state_t  state;
    logic [2:0] sync;      // [0],[1] synchronizer, [2] edge-detect delay
    logic       rx_s;
    logic       fall;
    logic       start_det;
    logic       tick;
    logic [3:0] smp_cnt;
    logic [2:0] bit_cnt;
    logic [2:0] smp;
    logic [7:0] shreg;

    assign rx_s      = sync[1];
    assign fall      = sync[2] & ~sync[1];
    assign start_det = (state == IDLE) && fall;
    assign rx_busy   = (state != IDLE);
    assign clk_da    = clk;

    uart_rx_baud_tick #(.CLK_FREQ(CLK_FREQ)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state != IDLE),
        .load     (start_det),
        .baud_set (baud_set),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the synchronizer resets to 0 rather than to the idle level.
            // A line that is already low when reset is released then produces
            // no high->low transition, so it is not taken as a start bit.
            sync      <= 3'b000;
            state     <= IDLE;
            smp_cnt   <= '0;
            bit_cnt   <= '0;
            smp       <= '0;
            shreg     <= '0;
            data_byte <= '0;
            dac_data  <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync      <= {sync[1:0], rs232_rx};
            rx_done   <= 1'b0;
            frame_err <= 1'b0;

            if (state == IDLE) begin
                if (fall) begin
                    state   <= START;
                    smp_cnt <= '0;
                    bit_cnt <= '0;
                end
            end else if (tick) begin
                smp_cnt <= smp_cnt + 4'd1;   // wraps 15 -> 0 at each bit boundary

                case (smp_cnt)
                    SMP_A:   smp[0] <= rx_s;
                    SMP_B:   smp[1] <= rx_s;
                    SMP_C:   smp[2] <= rx_s;
                    default: ;
                endcase

                case (state)
                    START: begin
                        // A start bit that votes high was a glitch: go back quietly.
                        if (smp_cnt == SMP_LAST) begin
                            state <= maj3(smp) ? IDLE : DATA;
                        end
                    end
                    DATA: begin
                        if (smp_cnt == SMP_LAST) begin
                            shreg   <= {maj3(smp), shreg[7:1]};   // LSB first
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= STOP;
                            end
                        end
                    end
                    STOP: begin
                        // Decide at mid-stop-bit so the receiver is already back
                        // in IDLE when a back-to-back start edge arrives.
                        if (smp_cnt == SMP_C) begin
                            state   <= IDLE;
                            smp_cnt <= '0;
                            if (maj3({rx_s, smp[1:0]})) begin
                                data_byte <= shreg;
                                dac_data  <= shreg;
                                rx_done   <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/da_uart_rx.md
# da_uart_rx

UART byte receiver feeding a DAC holding register: the return path to the ADC-sample UART transmitter. It recovers 8N1 frames from the serial line using 16x oversampling and majority voting. Each valid byte is presented as a one-cycle strobe and latched onto an 8-bit DAC data bus clocked by the system clock. Baud selection uses the same 3-bit code as the transmitter, so a host loopback runs both ends at one setting.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz; sets baud divisors.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- baud_set  in  3  0=9600, 1=19200, 2=38400, 3=57600, 4=115200; codes 5–7 select 9600.
- rs232_rx  in  1  asynchronous serial line, idle high.
- data_byte  out  8  last valid received byte.
- rx_done  out  1  one-cycle pulse: valid frame received.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- rx_busy  out  1  high while not in IDLE.
- dac_data  out  8  DAC data bus; updates only on valid frames.
- clk_da  out  1  DAC clock, equal to clk (combinational pass-through).

## Operation
- Input path: 2-flop synchronizer on rs232_rx, then a third register for edge detection. The start condition is a synchronized high→low transition.
- Oversample tick: divisor DIV = CLK_FREQ/(baud*16), integer-truncated; at 50 MHz this gives 325/162/81/54/27. The tick counter runs 0..DIV-1, emits one tick at DIV-1, and is held at 0 in IDLE.
- Per-bit sample counter runs 0..15 on ticks. Samples taken at counts 6, 7, 8; the bit value is the majority of the three.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on falling edge; the tick and sample counters clear.
  - START: at sample count 15, majority 1 (glitch) → IDLE with no outputs; majority 0 → DATA.
  - DATA: 8 bits, LSB first, shifted into the shift register at sample count 15. After bit 7 → STOP.
  - STOP: at sample count 8, evaluate the majority.
    - Majority 1: data_byte and dac_data ← shift register, rx_done=1 for one cycle.
    - Majority 0: frame_err=1 for one cycle; data_byte and dac_data unchanged.
    - Either way → IDLE on the same edge, so a back-to-back start edge at the nominal stop-bit end is caught.
- A falling edge while not in IDLE is ignored.
- A baud_set change takes effect at the next IDLE → START transition; the divisor is latched on that transition.
- rx_done and frame_err are never asserted together.

## Timing
- Reset values: data_byte=0x00, dac_data=0x00, rx_done=0, frame_err=0, rx_busy=0, FSM=IDLE, all counters 0.
- Synchronizer latency: 2 cycles, plus 1 for edge detection.
- Latency from the line falling edge to rx_done: 3 + (9*16 + 9) * DIV cycles, ±1 tick.
  - At DIV=27: 3 + 153*27 = 4134 cycles.
- rx_busy rises the cycle after the edge is detected and falls together with the rx_done/frame_err pulse.
- Reset asserted mid-frame: all state returns to reset values on the next edge; the partial byte is discarded. After release, the receiver waits for a fresh falling edge. A line already low at release is not treated as a start.

## Structure
- Package uart_pkg:
  - baud code constants;
  - divisor function div_of(CLK_FREQ, code);
  - FSM state enum (IDLE, START, DATA, STOP);
  - OVS=16 and sample-index constants 6/7/8/15.
- One sub-module, uart_rx_baud_tick: divisor latch, tick counter, tick output, enable input. The FSM, synchronizer, shift register and DAC register stay in the top.

## Test plan
- Valid frame: baud_set=4, send 0x55 → rx_done pulse ~4134 cycles after the edge; data_byte=0x55; dac_data=0x55; frame_err=0.
- Back-to-back frames at 115200: send 0xA3 then 0x3C with no idle gap → two rx_done pulses; dac_data=0xA3 then 0x3C.
- Glitch: 100-cycle low pulse at baud_set=4 → no rx_done, no frame_err; rx_busy drops by start-bit sample 15.
- Frame error: 0xF0 with the stop bit driven low → frame_err pulse, rx_done=0, dac_data keeps the previous 0x3C.
- Reset mid-frame: rst_n low during bit 4 of 0x81, then resend 0x81 → first frame produces nothing; second gives data_byte=0x81.
- Baud code 7: send 0x12 at 9600 (DIV=325) → received as 0x12; a baud_set change mid-frame does not corrupt the frame in flight.
